// File: rtl/muxn_hpc1_pkg.sv
// Shared definitions for the HPC1 masked multiplexer family: share count,
// per-gadget randomness budget and the index helpers used to slice packed
// share vectors and the randomness bus.
package muxn_hpc1_pkg;

   // Number of Boolean shares for a given probing order.
   function automatic int num_shares(input int order);
      return order + 1;
   endfunction

   // Number of unordered share pairs (i < j) for d shares.
   function automatic int pair_count(input int d);
      return (d * (d - 1)) / 2;
   endfunction

   // Fresh bits per HPC1 AND: one refresh bit plus one DOM bit per pair.
   function automatic int rnd_per_and(input int d);
      return d * (d - 1);
   endfunction

   // Dense index of share pair (i, j), i < j, within one block of pair bits.
   function automatic int pair_idx(input int i, input int j, input int d);
      return i * d - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   // Number of tree muxes that sit in the levels below level l.
   function automatic int level_base(input int l, input int n);
      return n - (n >> l);
   endfunction

   // Tree node feeding the even input of mux m at level l.
   // Nodes 0..n-1 are the input words; node n+g is the output of mux g.
   function automatic int src_node(input int l, input int m, input int n);
      if (l == 0) begin
         return 2 * m;
      end else begin
         return n + level_base(l - 1, n) + 2 * m;
      end
   endfunction

endpackage

// File: rtl/muxn_hpc1_mux2.sv
// Masked 2:1 word mux built from HPC1 AND gadgets.
// out = b ^ (s & (a ^ b)); the AND is the only non-linear step and uses one
// HPC1 gadget per bit, all sharing the same select shares.

// HPC1 AND gadget: z = a & b on d shares. Operand b is refreshed first,
// then multiplied DOM-style with one fresh bit per cross pair.
module hpc1_and
   import muxn_hpc1_pkg::*;
#(
   parameter  int D        = 3,
   parameter  int PIPELINE = 1,
   localparam int NP       = pair_count(D),
   localparam int RND      = rnd_per_and(D)
) (
   input  logic           clk,
   input  logic [D-1:0]   a,
   input  logic [D-1:0]   b,
   input  logic [RND-1:0] rnd,
   output logic [D-1:0]   z
);

   logic [D-1:0]   b_ref_s;
   logic [D-1:0]   a_use_s;
   logic [D-1:0]   b_use_s;
   logic [D*D-1:0] prod_s;
   logic [D*D-1:0] prod_use_s;
   logic [D-1:0]   z_s;

   // Refresh b: each pair bit is added to both shares of its pair.
   always_comb begin
      b_ref_s = b;
      for (int i = 0; i < D; i++) begin
         for (int j = i + 1; j < D; j++) begin
            b_ref_s[i] = b_ref_s[i] ^ rnd[pair_idx(i, j, D)];
            b_ref_s[j] = b_ref_s[j] ^ rnd[pair_idx(i, j, D)];
         end
      end
   end

   generate
      if (PIPELINE != 0) begin : g_reg
         logic [D-1:0]   a_r;
         logic [D-1:0]   b_ref_r;
         logic [D*D-1:0] prod_r;

         // First stage: refreshed b and a realigned; share registers are never reset.
         always_ff @(posedge clk) begin
            a_r     <= a;
            b_ref_r <= b_ref_s;
         end

         // Second stage: cross products settle in registers before compression.
         always_ff @(posedge clk) begin
            prod_r <= prod_s;
         end

         assign a_use_s    = a_r;
         assign b_use_s    = b_ref_r;
         assign prod_use_s = prod_r;
      end else begin : g_comb
         logic clk_unused_s;
         assign clk_unused_s = clk;
         assign a_use_s      = a;
         assign b_use_s      = b_ref_s;
         assign prod_use_s   = prod_s;
      end
   endgenerate

   // DOM cross products; both products of a pair share one fresh mask bit.
   always_comb begin
      prod_s = {(D*D){1'b0}};
      for (int i = 0; i < D; i++) begin
         for (int j = 0; j < D; j++) begin
            if (i == j) begin
               prod_s[i*D+j] = a_use_s[i] & b_use_s[j];
            end else if (i < j) begin
               prod_s[i*D+j] = (a_use_s[i] & b_use_s[j]) ^ rnd[NP + pair_idx(i, j, D)];
            end else begin
               prod_s[i*D+j] = (a_use_s[i] & b_use_s[j]) ^ rnd[NP + pair_idx(j, i, D)];
            end
         end
      end
   end

   // Compress row i of the product matrix into output share i.
   always_comb begin
      z_s = {D{1'b0}};
      for (int i = 0; i < D; i++) begin
         for (int j = 0; j < D; j++) begin
            z_s[i] = z_s[i] ^ prod_use_s[i*D+j];
         end
      end
   end

   assign z = z_s;

endmodule

// WIDTH-bit masked 2:1 mux: sel = 1 picks a_word, sel = 0 picks b_word.
module mux2_hpc1_word
   import muxn_hpc1_pkg::*;
#(
   parameter  int D        = 3,
   parameter  int WIDTH    = 8,
   parameter  int PIPELINE = 1,
   localparam int WD       = WIDTH * D,
   localparam int RND      = rnd_per_and(D)
) (
   input  logic                 clk,
   input  logic [WD-1:0]        a_word,
   input  logic [WD-1:0]        b_word,
   input  logic [D-1:0]         sel,
   input  logic [WIDTH*RND-1:0] rnd,
   output logic [WD-1:0]        out_word
);

   logic [WD-1:0] diff_s;
   logic [WD-1:0] and_s;
   logic [WD-1:0] b_dly_s;

   assign diff_s = a_word ^ b_word;

   generate
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
         hpc1_and #(
            .D        (D),
            .PIPELINE (PIPELINE)
         ) u_and (
            .clk (clk),
            .a   (diff_s[j*D +: D]),
            .b   (sel),
            .rnd (rnd[j*RND +: RND]),
            .z   (and_s[j*D +: D])
         );
      end

      if (PIPELINE != 0) begin : g_bdly
         logic [WD-1:0] b_d1_r;
         logic [WD-1:0] b_d2_r;

         // Two-stage delay of b to meet the gadget output; shares stay separate.
         always_ff @(posedge clk) begin
            b_d1_r <= b_word;
            b_d2_r <= b_d1_r;
         end

         assign b_dly_s = b_d2_r;
      end else begin : g_bwire
         assign b_dly_s = b_word;
      end
   endgenerate

   assign out_word = b_dly_s ^ and_s;

endmodule

// File: rtl/muxn_hpc1.sv
// Masked N:1 word multiplexer: a LOG2N-level tree of HPC1 2:1 word muxes,
// per-level select delay lines and a public valid pipeline. Output shares are
// forced to zero whenever the (public) valid tag is low.
module muxn_hpc1
   import muxn_hpc1_pkg::*;
#(
   parameter  int SECURITY_ORDER = 2,
   parameter  int WIDTH          = 8,
   parameter  int LOG2N          = 2,
   parameter  int PIPELINE       = 1,
   localparam int D              = num_shares(SECURITY_ORDER),
   localparam int N              = 1 << LOG2N,
   localparam int WD             = WIDTH * D,
   localparam int RND_PER_AND    = rnd_per_and(D),
   localparam int NODES          = 2 * N - 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   input  logic [N*WD-1:0]                  in_data,
   input  logic [LOG2N*D-1:0]               in_sel,
   input  logic [(N-1)*WIDTH*RND_PER_AND-1:0] rnd,
   output logic                             out_valid,
   output logic [WD-1:0]                    out_data
);

   logic [NODES*WD-1:0]  node_s;
   logic [LOG2N*D-1:0]   sel_lvl_s;
   logic [WD-1:0]        root_s;
   logic [WD-1:0]        out_data_s;
   logic                 out_valid_s;

   assign node_s[N*WD-1:0] = in_data;

   generate
      // Select bit l must arrive 2*l cycles late to meet level-l data.
      for (genvar l = 0; l < LOG2N; l++) begin : g_sel
         if (PIPELINE == 0 || l == 0) begin : g_wire
            assign sel_lvl_s[l*D +: D] = in_sel[l*D +: D];
         end else begin : g_dly
            logic [2*l-1:0][D-1:0] sdly_r;

            // Share-wise select delay line, no recombination, no reset.
            always_ff @(posedge clk) begin
               sdly_r[0] <= in_sel[l*D +: D];
               for (int k = 1; k < 2 * l; k++) begin
                  sdly_r[k] <= sdly_r[k-1];
               end
            end

            assign sel_lvl_s[l*D +: D] = sdly_r[2*l-1];
         end
      end

      // Mux tree; randomness sliced level-major, then mux, then bit.
      for (genvar l = 0; l < LOG2N; l++) begin : g_lvl
         for (genvar m = 0; m < (N >> (l + 1)); m++) begin : g_mux
            localparam int G   = level_base(l, N) + m;
            localparam int SRC = src_node(l, m, N);

            mux2_hpc1_word #(
               .D        (D),
               .WIDTH    (WIDTH),
               .PIPELINE (PIPELINE)
            ) u_mux (
               .clk      (clk),
               .a_word   (node_s[(SRC+1)*WD +: WD]),
               .b_word   (node_s[SRC*WD +: WD]),
               .sel      (sel_lvl_s[l*D +: D]),
               .rnd      (rnd[G*WIDTH*RND_PER_AND +: WIDTH*RND_PER_AND]),
               .out_word (node_s[(N+G)*WD +: WD])
            );
         end
      end

      if (PIPELINE != 0) begin : g_vld
         localparam int LAT = 2 * LOG2N;
         logic [LAT-1:0] vld_r;

         // Valid tags follow the data; reset drops everything in flight.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_r <= {LAT{1'b0}};
            end else begin
               vld_r <= {vld_r[LAT-2:0], in_valid};
            end
         end

         assign out_valid_s = vld_r[LAT-1];
      end else begin : g_novld
         logic rst_unused_s;
         assign rst_unused_s = rst_n;
         assign out_valid_s  = in_valid;
      end
   endgenerate

   assign root_s = node_s[(NODES-1)*WD +: WD];

   // Gate output shares with the public valid tag.
   always_comb begin
      if (out_valid_s) begin
         out_data_s = root_s;
      end else begin
         out_data_s = {WD{1'b0}};
      end
   end

   assign out_valid = out_valid_s;
   assign out_data  = out_data_s;

endmodule

// File: tb/tb_muxn_hpc1.sv
// Directed bench for muxn_hpc1: scoreboard of expected unmasked words with
// due cycles, pipelined instance plus a combinational instance.
module tb_muxn_hpc1;

   localparam int SO  = 2;
   localparam int D   = SO + 1;
   localparam int W   = 8;
   localparam int L2  = 2;
   localparam int N   = 4;
   localparam int RND = D * (D - 1);
   localparam int WD  = W * D;
   localparam int RW  = (N - 1) * W * RND;
   localparam int LAT = 2 * L2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             in_valid;
   logic [N*WD-1:0]  in_data;
   logic [L2*D-1:0]  in_sel;
   logic [RW-1:0]    rnd;
   logic             out_valid;
   logic [WD-1:0]    out_data;

   logic             p0_in_valid;
   logic [N*WD-1:0]  p0_in_data;
   logic [L2*D-1:0]  p0_in_sel;
   logic [RW-1:0]    p0_rnd;
   logic             p0_out_valid;
   logic [WD-1:0]    p0_out_data;

   typedef struct {
      logic [W-1:0] val;
      int           due;
   } exp_t;

   exp_t          exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   logic          mask_on = 1'b0;
   logic [WD-1:0] seen1;
   logic [WD-1:0] seen0;

   muxn_hpc1 #(.SECURITY_ORDER(SO), .WIDTH(W), .LOG2N(L2), .PIPELINE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_sel(in_sel), .rnd(rnd), .out_valid(out_valid), .out_data(out_data)
   );

   muxn_hpc1 #(.SECURITY_ORDER(SO), .WIDTH(W), .LOG2N(L2), .PIPELINE(0)) dut_p0 (
      .clk(clk), .rst_n(rst_n), .in_valid(p0_in_valid), .in_data(p0_in_data),
      .in_sel(p0_in_sel), .rnd(p0_rnd), .out_valid(p0_out_valid), .out_data(p0_out_data)
   );

   function automatic logic [WD-1:0] share_word(input logic [W-1:0] v);
      logic [WD-1:0] r;
      logic          acc;
      for (int j = 0; j < W; j++) begin
         acc = v[j];
         for (int i = 0; i < D - 1; i++) begin
            r[j*D+i] = 1'($urandom_range(0, 1));
            acc      = acc ^ r[j*D+i];
         end
         r[j*D+D-1] = acc;
      end
      return r;
   endfunction

   function automatic logic [L2*D-1:0] share_sel(input logic [L2-1:0] s);
      logic [L2*D-1:0] r;
      logic            acc;
      for (int k = 0; k < L2; k++) begin
         acc = s[k];
         for (int i = 0; i < D - 1; i++) begin
            r[k*D+i] = 1'($urandom_range(0, 1));
            acc      = acc ^ r[k*D+i];
         end
         r[k*D+D-1] = acc;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] unmask(input logic [WD-1:0] w);
      logic [W-1:0] v;
      v = {W{1'b0}};
      for (int j = 0; j < W; j++) begin
         for (int i = 0; i < D; i++) begin
            v[j] = v[j] ^ w[j*D+i];
         end
      end
      return v;
   endfunction

   function automatic logic [RW-1:0] rand_rnd();
      logic [RW-1:0] r;
      for (int k = 0; k < RW; k++) begin
         r[k] = 1'($urandom_range(0, 1));
      end
      return r;
   endfunction

   task automatic check_out();
      exp_t e;
      logic late;
      if (out_valid === 1'b1) begin
         n_tests++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL spurious_valid: out_valid=1 at cycle %0d, required 0", cyc);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            assert (unmask(out_data) === e.val) else begin
               n_fail++;
               $error("FAIL data: got %h required %h at cycle %0d", unmask(out_data), e.val, cyc);
            end
            n_tests++;
            assert (cyc === e.due) else begin
               n_fail++;
               $error("FAIL latency: output at cycle %0d required %0d", cyc, e.due);
            end
         end
         if (mask_on) begin
            seen1 = seen1 | out_data;
            seen0 = seen0 | ~out_data;
         end
      end else begin
         n_tests++;
         assert (out_data === {WD{1'b0}}) else begin
            n_fail++;
            $error("FAIL gate_zero: out_data=%h required 0", out_data);
         end
         late = 1'b0;
         if (exp_q.size() > 0) begin
            late = (exp_q[0].due <= cyc);
         end
         n_tests++;
         assert (late === 1'b0) else begin
            n_fail++;
            $error("FAIL missing_valid: out_valid=0 at cycle %0d required 1", cyc);
            e = exp_q.pop_front();
         end
      end
   endtask

   task automatic drive(input logic v, input logic [L2-1:0] sel, input logic [31:0] words);
      exp_t e;
      in_valid = v;
      for (int n = 0; n < N; n++) begin
         in_data[n*WD +: WD] = share_word(words[n*W +: W]);
      end
      in_sel = share_sel(sel);
      rnd    = rand_rnd();
      if (v && rst_n) begin
         e.val = words[sel*W +: W];
         e.due = cyc + LAT;
         exp_q.push_back(e);
      end
      @(negedge clk);
      check_out();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      logic [31:0] w;
      logic        ok;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = {(N*WD){1'b0}};
      in_sel      = {(L2*D){1'b0}};
      rnd         = {RW{1'b0}};
      p0_in_valid = 1'b0;
      p0_in_data  = {(N*WD){1'b0}};
      p0_in_sel   = {(L2*D){1'b0}};
      p0_rnd      = {RW{1'b0}};
      seen1       = {WD{1'b0}};
      seen0       = {WD{1'b0}};

      // reset state
      #12;
      n_tests++;
      assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL rst_valid: got %b required 0", out_valid); end
      n_tests++;
      assert (out_data === {WD{1'b0}}) else begin n_fail++; $error("FAIL rst_data: got %h required 0", out_data); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single pulse, sel = 2 -> 0x33
      drive(1'b1, 2'd2, 32'h44332211);
      for (int k = 0; k < 6; k++) drive(1'b0, 2'($urandom_range(0, 3)), $urandom);

      // streaming, sel cycling
      for (int k = 0; k < 16; k++) drive(1'b1, 2'(k), $urandom);
      for (int k = 0; k < 6; k++) drive(1'b0, 2'd0, $urandom);

      // reset while items are in flight and one is at the output
      for (int k = 0; k < 4; k++) drive(1'b1, 2'(k), $urandom);
      #2;
      n_tests++;
      assert (out_valid === 1'b1) else begin n_fail++; $error("FAIL pre_rst_valid: got %b required 1", out_valid); end
      rst_n = 1'b0;
      #1;
      n_tests++;
      assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL midrst_valid: got %b required 0", out_valid); end
      n_tests++;
      assert (out_data === {WD{1'b0}}) else begin n_fail++; $error("FAIL midrst_data: got %h required 0", out_data); end
      exp_q.delete();
      drive(1'b1, 2'd1, $urandom);
      drive(1'b1, 2'd2, $urandom);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) drive(1'b0, 2'd0, $urandom);
      drive(1'b1, 2'd3, 32'hDEADBEEF);
      for (int k = 0; k < 6; k++) drive(1'b0, 2'd0, $urandom);

      // mask independence: same word, fresh sharings
      w       = 32'hC3A55A3C;
      mask_on = 1'b1;
      for (int k = 0; k < 1000; k++) drive(1'b1, 2'd1, w);
      for (int k = 0; k < 6; k++) drive(1'b0, 2'd1, w);
      mask_on = 1'b0;
      for (int i = 0; i < D; i++) begin
         ok = 1'b1;
         for (int j = 0; j < W; j++) begin
            ok = ok & seen1[j*D+i] & seen0[j*D+i];
         end
         n_tests++;
         assert (ok === 1'b1) else begin n_fail++; $error("FAIL mask_share%0d: toggled=%b required 1", i, ok); end
      end

      // combinational instance
      for (int k = 0; k < 4; k++) begin
         w = (k == 0) ? 32'h00A50000 : $urandom;
         w[15:8] = 8'hA5;
         p0_in_valid = 1'b1;
         for (int n = 0; n < N; n++) p0_in_data[n*WD +: WD] = share_word(w[n*W +: W]);
         p0_in_sel = share_sel((k == 0) ? 2'd1 : 2'(k));
         p0_rnd    = rand_rnd();
         #1;
         n_tests++;
         assert (p0_out_valid === 1'b1) else begin n_fail++; $error("FAIL p0_valid: got %b required 1", p0_out_valid); end
         n_tests++;
         assert (unmask(p0_out_data) === w[((k == 0) ? 1 : k)*W +: W]) else begin
            n_fail++;
            $error("FAIL p0_data: got %h required %h", unmask(p0_out_data), w[((k == 0) ? 1 : k)*W +: W]);
         end
      end
      p0_in_valid = 1'b0;
      #1;
      n_tests++;
      assert (p0_out_valid === 1'b0) else begin n_fail++; $error("FAIL p0_idle_valid: got %b required 0", p0_out_valid); end
      n_tests++;
      assert (p0_out_data === {WD{1'b0}}) else begin n_fail++; $error("FAIL p0_idle_data: got %h required 0", p0_out_data); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
